ascending_sorter_3inputs_8bits: RTL and testbench

Pipelined three-input ascending sorter for unsigned pixel values. It is the building block of the 3x3 median filter: each instance sorts one window column or row into min/mid/max. It uses a three-stage registered compare-exchange network and accepts a new triple every clock.

---
 rtl/ascending_sorter_3inputs_8bits.sv | 132 +++++++++++++
 tb/tb_ascending_sorter_3inputs_8bits.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascending_sorter_3inputs_8bits.sv
// ascending_sorter_3inputs_8bits
//
// Purpose:
//   Three-stage pipelined sorting network for three unsigned samples. It is
//   used as the column/row sorter inside a 3x3 median filter. A new triple is
//   accepted every clock and its sorted result appears exactly three clock
//   edges later. There is no backpressure.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears all pipeline state
//   in_valid   qualifies in0/in1/in2 this cycle
//   in0..in2   unsigned input samples, WIDTH bits each
//   out_valid  min/mid/max hold a sorted result (in_valid delayed by 3)
//   min        smallest of the triple
//   mid        median of the triple
//   max        largest of the triple
//
// Handshake: valid-only streaming. A triple is taken on every rising edge.
// in_valid travels alongside the data, and out_valid marks the cycles in
// which min/mid/max belong to a real input. The data registers load on every
// cycle whatever in_valid is, so consumers must qualify the data with
// out_valid.

module ascending_sorter_3inputs_8bits #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] mid,
  output logic [WIDTH-1:0] max
);

  // Stage 1: compare-exchange (in0, in1), in2 passes through.
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_lo_q, s1_lo_d;
  logic [WIDTH-1:0] s1_hi_q, s1_hi_d;
  logic [WIDTH-1:0] s1_pass_q, s1_pass_d;

  // Stage 2: compare-exchange (hi1, in2), lo1 passes through.
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_lo_q, s2_lo_d;
  logic [WIDTH-1:0] s2_t_q, s2_t_d;
  logic [WIDTH-1:0] s2_max_q, s2_max_d;

  // Stage 3: compare-exchange (lo1, t), max passes through.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] mid_q, mid_d;
  logic [WIDTH-1:0] max_q, max_d;

  always_comb begin
    s1_valid_d = in_valid;
    s1_pass_d  = in2;
    if (in0 <= in1) begin
      s1_lo_d = in0;
      s1_hi_d = in1;
    end else begin
      s1_lo_d = in1;
      s1_hi_d = in0;
    end
  end

  // After stage 1, hi1 is the larger of the first pair, so the larger of
  // hi1 and in2 is already the overall maximum.
  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_lo_d    = s1_lo_q;
    if (s1_hi_q <= s1_pass_q) begin
      s2_t_d   = s1_hi_q;
      s2_max_d = s1_pass_q;
    end else begin
      s2_t_d   = s1_pass_q;
      s2_max_d = s1_hi_q;
    end
  end

  // The two remaining candidates (lo1 and t) hold the minimum and the median.
  always_comb begin
    out_valid_d = s2_valid_q;
    max_d       = s2_max_q;
    if (s2_lo_q <= s2_t_q) begin
      min_d = s2_lo_q;
      mid_d = s2_t_q;
    end else begin
      min_d = s2_t_q;
      mid_d = s2_lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_lo_q     <= '0;
      s1_hi_q     <= '0;
      s1_pass_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_lo_q     <= '0;
      s2_t_q      <= '0;
      s2_max_q    <= '0;
      out_valid_q <= 1'b0;
      min_q       <= '0;
      mid_q       <= '0;
      max_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_lo_q     <= s1_lo_d;
      s1_hi_q     <= s1_hi_d;
      s1_pass_q   <= s1_pass_d;
      s2_valid_q  <= s2_valid_d;
      s2_lo_q     <= s2_lo_d;
      s2_t_q      <= s2_t_d;
      s2_max_q    <= s2_max_d;
      out_valid_q <= out_valid_d;
      min_q       <= min_d;
      mid_q       <= mid_d;
      max_q       <= max_d;
    end
  end

  assign out_valid = out_valid_q;
  assign min       = min_q;
  assign mid       = mid_q;
  assign max       = max_q;

endmodule

// File: tb/tb_ascending_sorter_3inputs_8bits.sv
// Testbench for ascending_sorter_3inputs_8bits.
// A driver task applies one triple per cycle and pushes the model's sorted
// result onto exp_q. Each test task compares the DUT outputs against the queue
// on the falling edge.

module tb_ascending_sorter_3inputs_8bits;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in0, in1, in2;
  logic       out_valid;
  logic [7:0] min, mid, max;

  logic [23:0] exp_q[$];
  logic [23:0] exp_v;
  logic [2:0]  vld_hist;
  int          vectors;
  int          miscompares;

  ascending_sorter_3inputs_8bits #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .min       (min),
    .mid       (mid),
    .max       (max)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference valid pipeline: in_valid sampled on each edge, three deep.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_hist <= 3'b000;
    else        vld_hist <= {vld_hist[1:0], in_valid};
  end

  // ---------------- reference model ----------------
  // The median is the total minus the extremes.
  function automatic logic [23:0] sort_model(input int a, input int b, input int c);
    int mn, mx, md;
    mn = a; if (b < mn) mn = b; if (c < mn) mn = c;
    mx = a; if (b > mx) mx = b; if (c > mx) mx = c;
    md = a + b + c - mn - mx;
    return {8'(mn), 8'(md), 8'(mx)};
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic v, input int a, input int b, input int c);
    @(posedge clk);
    #1;
    in_valid = v;
    in0      = 8'(a);
    in1      = 8'(b);
    in2      = 8'(c);
    if (v) exp_q.push_back(sort_model(a, b, c));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in0 = 8'd200; in1 = 8'd17; in2 = 8'd99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({out_valid, min, mid, max} !== 25'd0) begin
        miscompares++;
        $display("FAIL reset_hold: got v=%b %0d,%0d,%0d want v=0 0,0,0", out_valid, min, mid, max);
      end
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive_cycle(1'b1, 45, 12, 78);
      else        drive_cycle(1'b0, 0, 0, 0);
      @(negedge clk);
      vectors++;
      if (out_valid !== vld_hist[2]) begin
        miscompares++;
        $display("FAIL reset_first out_valid: got %b want %b", out_valid, vld_hist[2]);
      end
      if (out_valid === 1'b1) begin
        vectors++;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        if ({min, mid, max} !== exp_v) begin
          miscompares++;
          $display("FAIL reset_first data: got %0d,%0d,%0d want %0d,%0d,%0d",
                   min, mid, max, exp_v[23:16], exp_v[15:8], exp_v[7:0]);
        end
      end
    end
  endtask

  task automatic test_orderings();
    int t[6][3] = '{'{5, 50, 100}, '{7, 200, 77}, '{60, 15, 150},
                    '{220, 33, 111}, '{80, 190, 9}, '{240, 95, 1}};
    for (int i = 0; i < 10; i++) begin
      if (i < 6) drive_cycle(1'b1, t[i][0], t[i][1], t[i][2]);
      else       drive_cycle(1'b0, 0, 0, 0);
      @(negedge clk);
      vectors++;
      if (out_valid !== vld_hist[2]) begin
        miscompares++;
        $display("FAIL orderings out_valid cyc %0d: got %b want %b", i, out_valid, vld_hist[2]);
      end
      if (out_valid === 1'b1) begin
        vectors++;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        if ({min, mid, max} !== exp_v) begin
          miscompares++;
          $display("FAIL orderings data cyc %0d: got %0d,%0d,%0d want %0d,%0d,%0d",
                   i, min, mid, max, exp_v[23:16], exp_v[15:8], exp_v[7:0]);
        end
      end
    end
  endtask

  task automatic test_duplicates();
    int t[6][3] = '{'{55, 55, 55}, '{40, 40, 80}, '{35, 99, 35},
                    '{180, 70, 70}, '{125, 125, 20}, '{145, 50, 145}};
    for (int i = 0; i < 10; i++) begin
      if (i < 6) drive_cycle(1'b1, t[i][0], t[i][1], t[i][2]);
      else       drive_cycle(1'b0, 0, 0, 0);
      @(negedge clk);
      vectors++;
      if (out_valid !== vld_hist[2]) begin
        miscompares++;
        $display("FAIL duplicates out_valid cyc %0d: got %b want %b", i, out_valid, vld_hist[2]);
      end
      if (out_valid === 1'b1) begin
        vectors++;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        if ({min, mid, max} !== exp_v) begin
          miscompares++;
          $display("FAIL duplicates data cyc %0d: got %0d,%0d,%0d want %0d,%0d,%0d",
                   i, min, mid, max, exp_v[23:16], exp_v[15:8], exp_v[7:0]);
        end
      end
    end
  endtask

  task automatic test_extremes();
    int t[5][3] = '{'{0, 0, 0}, '{255, 255, 255}, '{0, 128, 255},
                    '{100, 255, 50}, '{253, 254, 255}};
    for (int i = 0; i < 9; i++) begin
      if (i < 5) drive_cycle(1'b1, t[i][0], t[i][1], t[i][2]);
      else       drive_cycle(1'b0, 0, 0, 0);
      @(negedge clk);
      vectors++;
      if (out_valid !== vld_hist[2]) begin
        miscompares++;
        $display("FAIL extremes out_valid cyc %0d: got %b want %b", i, out_valid, vld_hist[2]);
      end
      if (out_valid === 1'b1) begin
        vectors++;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        if ({min, mid, max} !== exp_v) begin
          miscompares++;
          $display("FAIL extremes data cyc %0d: got %0d,%0d,%0d want %0d,%0d,%0d",
                   i, min, mid, max, exp_v[23:16], exp_v[15:8], exp_v[7:0]);
        end
      end
    end
  endtask

  // Valid gaps, followed by a random stream with random idle cycles.
  task automatic test_valid_gaps();
    int t[3][3] = '{'{89, 144, 55}, '{0, 0, 0}, '{97, 53, 149}};
    logic v;
    for (int i = 0; i < 30; i++) begin
      if (i < 3) begin
        if (i == 1) drive_cycle(1'b0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        else        drive_cycle(1'b1, t[i][0], t[i][1], t[i][2]);
      end else if (i < 26) begin
        v = ($urandom_range(0, 3) != 0);
        drive_cycle(v, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      end else begin
        drive_cycle(1'b0, 0, 0, 0);
      end
      @(negedge clk);
      vectors++;
      if (out_valid !== vld_hist[2]) begin
        miscompares++;
        $display("FAIL gaps out_valid cyc %0d: got %b want %b", i, out_valid, vld_hist[2]);
      end
      if (out_valid === 1'b1) begin
        vectors++;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        if ({min, mid, max} !== exp_v) begin
          miscompares++;
          $display("FAIL gaps data cyc %0d: got %0d,%0d,%0d want %0d,%0d,%0d",
                   i, min, mid, max, exp_v[23:16], exp_v[15:8], exp_v[7:0]);
        end
      end
    end
  endtask

  task automatic test_midstream_reset();
    // Three triples enter the pipe; the first is at the outputs when reset hits.
    drive_cycle(1'b1, 10, 30, 20);
    drive_cycle(1'b1, 99, 98, 97);
    drive_cycle(1'b1, 1, 2, 3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, min, mid, max} !== 25'd0) begin
      miscompares++;
      $display("FAIL midreset async clear: got v=%b %0d,%0d,%0d want v=0 0,0,0", out_valid, min, mid, max);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) drive_cycle(1'b1, 200, 100, 150);
      else        drive_cycle(1'b0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      @(negedge clk);
      vectors++;
      if (out_valid !== vld_hist[2]) begin
        miscompares++;
        $display("FAIL midreset out_valid cyc %0d: got %b want %b", i, out_valid, vld_hist[2]);
      end
      if (out_valid === 1'b1) begin
        vectors++;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        if ({min, mid, max} !== exp_v) begin
          miscompares++;
          $display("FAIL midreset data cyc %0d: got %0d,%0d,%0d want %0d,%0d,%0d",
                   i, min, mid, max, exp_v[23:16], exp_v[15:8], exp_v[7:0]);
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    in_valid    = 1'b0;
    in0 = 8'd0; in1 = 8'd0; in2 = 8'd0;
    test_reset();
    test_orderings();
    test_duplicates();
    test_extremes();
    test_valid_gaps();
    test_midstream_reset();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d results never produced want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
